// File: rtl/exp_arbiter_if.sv
// exp_arbiter_if: client request/response bus plus engine launch/result
// bus. master = the arbiter, slave = clients and engine side.
interface exp_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    reqValid;
  logic [16*N_REQ-1:0] reqX;
  logic [N_REQ-1:0]    reqGrant;
  logic [N_REQ-1:0]    respDone;
  logic [1:0]          respInt;
  logic [15:0]         respFrac;
  logic                respErr;
  logic                busy;
  logic                engFault;
  logic                engStart;
  logic [15:0]         engX;
  logic                engDone;
  logic [1:0]          engInt;
  logic [15:0]         engFrac;

  modport master (
    input  reqValid,
    input  reqX,
    input  engDone,
    input  engInt,
    input  engFrac,
    output reqGrant,
    output respDone,
    output respInt,
    output respFrac,
    output respErr,
    output busy,
    output engFault,
    output engStart,
    output engX
  );

  modport slave (
    output reqValid,
    output reqX,
    output engDone,
    output engInt,
    output engFrac,
    input  reqGrant,
    input  respDone,
    input  respInt,
    input  respFrac,
    input  respErr,
    input  busy,
    input  engFault,
    input  engStart,
    input  engX
  );
endinterface

// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin sharing of one exponential engine by N_REQ
// requesters, with an engine watchdog and one-hot registered responses.
// Ports: clk; rst (async, active high); bus (exp_arbiter_if.master):
//   reqValid/reqX in, reqGrant/respDone/respInt/respFrac/respErr,
//   busy/engFault out; engStart/engX out, engDone/engInt/engFrac in.
module exp_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4095
) (
  input logic           clk,
  input logic           rst,
  exp_arbiter_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt;
  logic [IW-1:0]    win;
  logic [IW-1:0]    idx;
  logic             found;
  logic [15:0]      wdog;
  logic             launch;
  logic             take;
  logic             expire;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] gnt_oh;
  logic [15:0]      win_x;

  // First pending requester scanning upward from ptr, with wrap.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + IW'(k);
      if (!found && bus.reqValid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_oh = N_REQ'(1) << win;
  assign gnt_oh = N_REQ'(1) << gnt;
  assign win_x  = bus.reqX[{win, 4'b0000} +: 16];

  assign launch = (state == S_IDLE) && found;
  assign take   = (state == S_WAIT) && bus.engDone;

  // A done arriving on the last watchdog cycle still wins.
  assign expire = (state == S_WAIT) && !bus.engDone
                  && (wdog == WD_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (launch) state_n = S_START;
      S_START: state_n = S_GUARD;
      S_GUARD: state_n = S_WAIT;
      S_WAIT:  if (take || expire) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ptr moves past the winner once granted, so a requester that
  // stays valid queues behind every other pending one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      gnt <= '0;
    end else begin
      if (launch) begin
        gnt <= win;
      end
      if (state == S_START) begin
        ptr <= gnt + IW'(1);
      end
    end
  end

  // GUARD clears the watchdog; engDone is not looked at there
  // because the engine may still hold it from the last operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == S_GUARD) begin
      wdog <= '0;
    end else if (state == S_WAIT && !take && !expire) begin
      wdog <= wdog + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.engStart <= 1'b0;
      bus.engX     <= '0;
      bus.reqGrant <= '0;
    end else begin
      bus.engStart <= launch;
      bus.reqGrant <= launch ? win_oh : '0;
      if (launch) begin
        bus.engX <= win_x;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.respDone <= '0;
      bus.respInt  <= '0;
      bus.respFrac <= '0;
      bus.respErr  <= 1'b0;
    end else begin
      bus.respDone <= (take || expire) ? gnt_oh : '0;
      if (take) begin
        bus.respInt  <= bus.engInt;
        bus.respFrac <= bus.engFrac;
        bus.respErr  <= 1'b0;
      end else if (expire) begin
        bus.respInt  <= '0;
        bus.respFrac <= '0;
        bus.respErr  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy     <= 1'b0;
      bus.engFault <= 1'b0;
    end else begin
      bus.busy     <= (state_n != S_IDLE);
      bus.engFault <= bus.engFault | expire;
    end
  end
endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: directed + random checks of exp_arbiter against a
// round-robin reference model and a latency-programmable engine stub.
module tb_exp_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  exp_arbiter_if #(.N_REQ(N)) ifc ();

  exp_arbiter #(
    .N_REQ(N),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  int eng_lat   = 1;
  bit eng_stale = 1'b0;
  int ecnt;
  logic [15:0] ex;
  logic [17:0] er;

  logic [N-1:0] pv;
  logic [15:0]  xv [N];
  int           mode;

  int          last;
  bit          fault_m;
  logic [1:0]  ri_m;
  logic [15:0] rf_m;
  bit          re_m;

  function automatic logic [17:0] eng_fn(input logic [15:0] x);
    eng_fn = {x[15:14] ^ x[1:0], (x * 16'd3) ^ 16'h5a5a};
  endfunction

  // Engine stub: done appears lat cycles after the cycle following
  // engStart. In stale mode done stays high and only the data moves.
  initial begin
    ifc.engDone = 1'b0;
    ifc.engInt  = '0;
    ifc.engFrac = '0;
    ecnt = -1;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        ecnt = -1;
        ifc.engDone = 1'b0;
      end else if (ifc.engStart) begin
        ex = ifc.engX;
        ecnt = eng_lat + 1;
        ifc.engDone = eng_stale;
      end else if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) begin
          er = eng_fn(ex);
          ifc.engInt  = er[17:16];
          ifc.engFrac = er[15:0];
          ifc.engDone = 1'b1;
        end else begin
          ifc.engDone = eng_stale;
        end
      end else begin
        ifc.engDone = eng_stale;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    ifc.reqValid = pv;
    ifc.reqX = {xv[3], xv[2], xv[1], xv[0]};
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {ifc.reqGrant, ifc.respDone, ifc.respInt,
              ifc.respFrac, ifc.respErr, ifc.busy,
              ifc.engFault, ifc.engStart, ifc.engX}, 0);
  endtask

  task automatic model_reset();
    last = N - 1;
    fault_m = 1'b0;
    ri_m = '0;
    rf_m = '0;
    re_m = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    chk_zero("rst_outs");
    repeat (n) step();
    rst = 1'b0;
    model_reset();
  endtask

  // One full operation, entered in an IDLE cycle with pv != 0.
  task automatic op(input int lat);
    int w;
    int j;
    logic [15:0] xw;
    logic [17:0] r;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (w < 0 && pv[j]) w = j;
    end
    xw = xv[w];
    eng_lat = lat;
    step();
    chk("grant", ifc.reqGrant, 1 << w);
    chk("start", ifc.engStart, 1);
    chk("engx", ifc.engX, xw);
    chk("busy_start", ifc.busy, 1);
    last = w;
    step();
    chk("guard_quiet",
        {ifc.reqGrant, ifc.engStart, ifc.respDone}, 0);
    case (mode)
      0: pv[w] = 1'b0;
      2: begin
        if ($urandom_range(0, 1) == 1) begin
          pv[w] = 1'b1;
          xv[w] = 16'($urandom);
        end else begin
          pv[w] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (!pv[i] && $urandom_range(0, 3) == 0) begin
            pv[i] = 1'b1;
            xv[i] = 16'($urandom);
          end
        end
      end
      default: ;
    endcase
    drive();
    for (int c = 0; c < ((lat > T) ? T : lat); c++) begin
      step();
      chk("wait_quiet", {ifc.respDone, ifc.busy}, 1);
    end
    if (lat > T) begin
      ri_m = '0;
      rf_m = '0;
      re_m = 1'b1;
      fault_m = 1'b1;
    end else begin
      r = eng_fn(xw);
      ri_m = r[17:16];
      rf_m = r[15:0];
      re_m = 1'b0;
    end
    step();
    chk("resp_done", ifc.respDone, 1 << w);
    chk("resp_data",
        {ifc.respInt, ifc.respFrac, ifc.respErr},
        {ri_m, rf_m, re_m});
    chk("fault", ifc.engFault, fault_m);
    chk("engx_hold", ifc.engX, xw);
    step();
    chk("idle_after",
        {ifc.respDone, ifc.busy, ifc.reqGrant}, 0);
    chk("resp_hold",
        {ifc.respInt, ifc.respFrac, ifc.respErr},
        {ri_m, rf_m, re_m});
  endtask

  initial begin
    pv = '0;
    for (int i = 0; i < N; i++) xv[i] = '0;
    mode = 0;
    model_reset();
    drive();
    #1;
    do_reset(5);
    step();
    chk("idle_busy", ifc.busy, 0);

    xv[0] = 16'h8000;
    pv = 4'b0001;
    drive();
    op(3);

    do_reset(2);
    for (int i = 0; i < N; i++) xv[i] = 16'(16'h1000 * (i + 1));
    pv = 4'b1111;
    mode = 1;
    drive();
    repeat (8) op($urandom_range(1, 6));
    pv = '0;
    drive();
    step();
    chk("rr_idle", {ifc.busy, ifc.reqGrant}, 0);

    mode = 0;
    xv[1] = 16'h1234;
    pv = 4'b0010;
    drive();
    op(1000);
    xv[3] = 16'h4321;
    pv = 4'b1000;
    drive();
    op(2);

    eng_stale = 1'b1;
    step();
    xv[2] = 16'hbeef;
    pv = 4'b0100;
    drive();
    op(1);
    eng_stale = 1'b0;

    mode = 2;
    for (int it = 0; it < 40; it++) begin
      if (pv == '0) begin
        step();
        chk("rnd_idle", {ifc.busy, ifc.reqGrant}, 0);
        pv = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) begin
          if (pv[i]) xv[i] = 16'($urandom);
        end
        drive();
      end
      op($urandom_range(1, T + 3));
    end

    pv = '0;
    drive();
    step();
    mode = 0;
    pv = 4'b0001;
    xv[0] = 16'h0f0f;
    drive();
    eng_lat = 1000;
    step();
    chk("mw_grant", ifc.reqGrant, 1);
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_zero("mw_rst_outs");
    xv[2] = 16'h2222;
    pv = 4'b0101;
    drive();
    repeat (3) begin
      step();
      chk("mw_quiet",
          {ifc.respDone, ifc.busy, ifc.reqGrant}, 0);
    end
    rst = 1'b0;
    model_reset();
    op(2);
    op(2);

    xv[3] = 16'h7777;
    pv = 4'b1000;
    drive();
    op(T);
    xv[2] = 16'h3c3c;
    pv = 4'b0100;
    drive();
    op(T + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/exp_arbiter.md
# exp_arbiter

Round-robin controller that shares one `exponential` engine between four requesters. It arbitrates pending requests and launches the engine with the winner's operand. It then waits for `engDone` under a watchdog and returns the `int`/`frac` result to the granted requester with a one-cycle completion pulse. It sits between the engine instance and its client blocks, which never drive the engine directly.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; fixed at 4 for this revision; the width of the per-requester ports.
- `TIMEOUT`, 4095: maximum number of WAIT cycles before the operation is aborted; range 2..65535.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reqValid`  in  N_REQ  per-requester request level; held until granted.
- `reqX`  in  16*N_REQ  packed operands; requester i drives `reqX[16*i+15:16*i]`.
- `reqGrant`  out  N_REQ  one-hot, one-cycle grant pulse.
- `respDone`  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- `respInt`  out  2  result integer part; valid while any `respDone` bit is high.
- `respFrac`  out  16  result fraction; valid while any `respDone` bit is high.
- `respErr`  out  1  high with `respDone` when the operation timed out.
- `busy`  out  1  high in every state except IDLE.
- `engFault`  out  1  sticky; set on the first timeout, cleared only by `rst`.
- `engStart`  out  1  engine start pulse.
- `engX`  out  16  engine operand; held stable from START until the next START.
- `engDone`  in  1  engine completion.
- `engInt`  in  2  engine integer result.
- `engFrac`  in  16  engine fraction result.

## Operation
- FSM states: IDLE, START, GUARD, WAIT, RESP. All outputs are registered.
- IDLE
  - `reqValid` is sampled only in IDLE.
  - If any bit is set, the winner is the first set bit scanning upward (wrapping) from `ptr`.
  - On the winner: `engX` <= winner's `reqX`, `gnt` <= winner index, next state START.
- START
  - `engStart`=1 and `reqGrant[gnt]`=1 for this single cycle.
  - `ptr` <= (`gnt`+1) mod 4.
  - Next state GUARD.
- GUARD
  - One cycle. `engDone` is ignored.
  - Covers an engine that still holds `engDone` from the previous operation; the engine drops it within one cycle of `engStart`.
  - Clear the watchdog counter `wdog`. Next state WAIT.
- WAIT
  - If `engDone`=1: capture `engInt`/`engFrac`, `respErr`<=0, next state RESP.
  - Else if `wdog`==TIMEOUT-1: `respInt`/`respFrac` <= 0, `respErr`<=1, `engFault`<=1, next state RESP.
  - Else `wdog`++.
  - If `engDone` and the timeout condition occur in the same cycle, `engDone` wins and the operation is not an error.
- RESP
  - `respDone[gnt]`=1 for one cycle. Next state IDLE.
  - `respInt`, `respFrac` and `respErr` hold their values until the next RESP.
- Round-robin fairness: a requester that keeps `reqValid` high after its grant is treated as a new request. It is served after every other pending requester.
- Reset (asynchronous, at any time, including mid-operation):
  - State returns to IDLE; `ptr`=0, so requester 0 has top priority.
  - All outputs go to 0, including `engX`, `respInt`, `respFrac` and `engFault`.
  - Any in-flight request is dropped; no `respDone` is issued for it.
- `reqX` of a non-winning requester is never sampled.

## Timing
- `reqValid` seen high at IDLE edge t:
  - cycle t+1: START (`reqGrant`, `engStart`);
  - cycle t+2: GUARD;
  - cycle t+3 onward: WAIT.
- `engDone` seen at WAIT edge e: `respDone` is high in cycle e+1.
- Fixed controller overhead: 4 cycles of total latency plus the engine's compute time.
- Back-to-back operations: the earliest next START is 2 cycles after RESP (RESP, then IDLE, then START).
- Timeout: RESP with `respErr` follows exactly TIMEOUT WAIT cycles after GUARD.
- Requesters hold `reqValid` and `reqX` until the `reqGrant` cycle. They may drop both in the cycle after `reqGrant`.

## Test plan
- Reset then single request: `rst` for 5 cycles, then `reqValid`=0001 with X=16'h8000. Required: `reqGrant`=0001 and `engStart` in the same cycle; `engX`=16'h8000; `respDone`=0001 with `respInt`/`respFrac` equal to the engine output; `respErr`=0; `busy` low after RESP.
- Round robin: all four requesters held valid for 8 operations with X=16'h1000*(i+1). Required grant order 0,1,2,3,0,1,2,3; each `respDone` goes to the matching index with that requester's result.
- Timeout: stub engine never asserts `engDone`, `TIMEOUT`=16. Required: `respDone` with `respErr`=1 and `respInt`=`respFrac`=0 exactly 16 cycles after GUARD; `engFault` stays 1 through later good operations.
- Stale done: `engDone` held high through START and GUARD. Required: it is not taken as completion until WAIT; a result captured in the first WAIT cycle is accepted.
- Reset mid-WAIT: assert `rst` during WAIT. Required: all outputs 0 immediately; no `respDone`; the next request from requester 2 while 0 is also pending grants 0 first.
- Done on the timeout edge: `engDone` arrives in the same cycle `wdog` hits TIMEOUT-1. Required: `respErr`=0 and `engFault` unchanged.
